// File: rtl/instr_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-memory load/fetch controller.
// The optional load checksum is enabled by defining INSTR_LOAD_CHECKSUM_EN.
package instr_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int WORD_W_DEF = 16;
  localparam int RD_W_DEF   = 8;
  localparam int CSUM_W     = 8;

  // Controller state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD_HI = 3'd1;
  localparam state_t ST_LOAD_LO = 3'd2;
  localparam state_t ST_WRITE   = 3'd3;
  localparam state_t ST_CHK     = 3'd4;

endpackage

// File: rtl/instr_fetch_pipe.sv
// Two-cycle fetch pipeline: registers the read address on accept and tracks
// the matching valid through the synchronous memory read.
module instr_fetch_pipe
  import instr_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic              fetch_valid
);

  logic [1:0] vld_sr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr     <= 2'b00;
      mem_r_addr <= '0;
    end else begin
      vld_sr <= {vld_sr[0], accept};
      if (accept) mem_r_addr <= fetch_addr;
    end
  end

  assign fetch_valid = vld_sr[1];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction-memory controller: packs host bytes into words for load sessions and
// serves pipelined core fetches while idle. INSTR_LOAD_CHECKSUM_EN adds a trailing checksum byte.
module instr_mem_ctrl
  import instr_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [RD_W-1:0]   fetch_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [WORD_W-1:0] mem_w_instr,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [RD_W-1:0]   mem_r_instr,
  output logic              busy_load,
  output logic              load_done,
  output logic              load_err
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, len_q;
  logic [WORD_W/2-1:0] hi_q, lo_q;
  logic                done_q;
  logic                rx_xfer, last_word, session_end, open_session;

  assign open_session = (state_q == ST_IDLE) && load_start;
  assign rx_xfer      = rx_valid && rx_ready;
  assign last_word    = (cnt_q == len_q);

`ifdef INSTR_LOAD_CHECKSUM_EN
  assign rx_ready    = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO) || (state_q == ST_CHK);
  assign session_end = (state_q == ST_CHK) && rx_xfer;
`else
  assign rx_ready    = (state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO);
  assign session_end = (state_q == ST_WRITE) && last_word;
`endif

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (load_start) state_d = ST_LOAD_HI;
      ST_LOAD_HI: if (rx_xfer) state_d = ST_LOAD_LO;
      ST_LOAD_LO: if (rx_xfer) state_d = ST_WRITE;
      ST_WRITE: begin
        if (!last_word) state_d = ST_LOAD_HI;
`ifdef INSTR_LOAD_CHECKSUM_EN
        else state_d = ST_CHK;
`else
        else state_d = ST_IDLE;
`endif
      end
`ifdef INSTR_LOAD_CHECKSUM_EN
      ST_CHK:     if (rx_xfer) state_d = ST_IDLE;
`endif
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= session_end;
      if (open_session) begin
        len_q <= load_len;
        cnt_q <= '0;
      end
      if ((state_q == ST_LOAD_HI) && rx_xfer) hi_q <= rx_data;
      if ((state_q == ST_LOAD_LO) && rx_xfer) lo_q <= rx_data;
      // Counter is exactly ADDR_W wide, so a full-depth session wraps it to 0.
      if (state_q == ST_WRITE) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef INSTR_LOAD_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q;
  logic              err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else if (open_session) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else if (rx_xfer && ((state_q == ST_LOAD_HI) || (state_q == ST_LOAD_LO))) begin
      csum_q <= csum_q + rx_data;
    end else if ((state_q == ST_CHK) && rx_xfer) begin
      err_q <= (rx_data != csum_q);
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  assign busy_load   = (state_q != ST_IDLE);
  assign load_done   = done_q;
  assign mem_we      = (state_q == ST_WRITE);
  assign mem_w_addr  = cnt_q;
  assign mem_w_instr = {hi_q, lo_q};

  // A simultaneous load_start wins over a fetch request.
  assign fetch_ready = (state_q == ST_IDLE) && !load_start;
  assign fetch_data  = mem_r_instr;

  instr_fetch_pipe #(.ADDR_W(ADDR_W)) u_fetch_pipe (
    .clk         (clk),
    .rst         (rst),
    .accept      (fetch_req && fetch_ready),
    .fetch_addr  (fetch_addr),
    .mem_r_addr  (mem_r_addr),
    .fetch_valid (fetch_valid)
  );

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl with a behavioural synchronous instruction memory.
// Covers both builds; checksum cases depend on INSTR_LOAD_CHECKSUM_EN.
module tb_instr_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, load_start, rx_valid, rx_ready, fetch_req, fetch_ready, fetch_valid;
  logic [7:0]  load_len, rx_data, fetch_addr, fetch_data, mem_w_addr, mem_r_addr, mem_r_instr;
  logic        mem_we, busy_load, load_done, load_err;
  logic [15:0] mem_w_instr;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  instr_mem_ctrl dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_w_instr(mem_w_instr),
    .mem_r_addr(mem_r_addr), .mem_r_instr(mem_r_instr),
    .busy_load(busy_load), .load_done(load_done), .load_err(load_err)
  );

  // Instruction memory model; reads return the low byte of the addressed word.
  // NOTE: memory arrays are not reset; only control state needs a known value.
  logic [15:0] mem_model [256];
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_w_addr] <= mem_w_instr;
    mem_r_instr <= mem_model[mem_r_addr][7:0];
  end

  always @(negedge clk) if (load_done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic ls; logic [7:0] len; logic fr; logic [7:0] fa; logic rv; logic [7:0] rd;
    logic e_rdy; logic e_frdy; logic e_fv; logic [7:0] e_fd;
    logic e_we; logic [7:0] e_wa; logic [15:0] e_wd; logic e_busy; logic e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ls, input logic [7:0] len, input logic fr, input logic [7:0] fa,
    input logic rv, input logic [7:0] rd,
    input logic e_rdy, input logic e_frdy, input logic e_fv, input logic [7:0] e_fd,
    input logic e_we, input logic [7:0] e_wa, input logic [15:0] e_wd,
    input logic e_busy, input logic e_done);
    vec_t v;
    v.ls = ls; v.len = len; v.fr = fr; v.fa = fa; v.rv = rv; v.rd = rd;
    v.e_rdy = e_rdy; v.e_frdy = e_frdy; v.e_fv = e_fv; v.e_fd = e_fd;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  // Session driver: rx_valid stays high while bytes remain, advancing on handshake.
  logic [7:0]  byte_q[$];
  logic [23:0] exp_w[$];
  int bad_writes, n_writes, busy_cycles;
  bit sess_done;

  task automatic run_session(input logic [7:0] len);
    int idx;
    int cyc;
    bit take;
    logic [23:0] want;
    idx = 0; cyc = 0; bad_writes = 0; n_writes = 0; busy_cycles = 0; sess_done = 0;
    load_start = 1'b1; load_len = len;
    tick();
    load_start = 1'b0;
    while (!sess_done && cyc < 2000) begin
      rx_valid = (idx < byte_q.size());
      rx_data  = rx_valid ? byte_q[idx] : 8'h00;
      @(negedge clk);
      take = rx_valid && rx_ready;
      if (busy_load) busy_cycles++;
      if (mem_we) begin
        n_writes++;
        if (exp_w.size() == 0) bad_writes++;
        else begin
          want = exp_w.pop_front();
          if ({mem_w_addr, mem_w_instr} !== want) bad_writes++;
        end
      end
      if (load_done) sess_done = 1;
      tick();
      if (take) idx++;
      cyc++;
    end
    rx_valid = 1'b0;
    check("session_completes", {31'd0, sess_done}, 32'd1);
  endtask

  int done_snap;
  logic [7:0] csum;

  initial begin
    rst = 1'b1; load_start = 0; load_len = 0; rx_data = 0; rx_valid = 0;
    fetch_req = 0; fetch_addr = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy_load, 0);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_fetch_ready", fetch_ready, 1);
    check("rst_mem_w_addr", mem_w_addr, 0);
    check("rst_mem_w_instr", mem_w_instr, 0);
    check("rst_mem_r_addr", mem_r_addr, 0);
    tick();

    // Load 3 words, with a colliding fetch on the load_start cycle, then fetch them back.
    vecs.push_back(mk(0,0,0,0,0,8'h00, 0,1,0,0,    0,0,0,      0,0));
    vecs.push_back(mk(1,2,1,5,0,8'h00, 0,0,0,0,    0,0,0,      0,0));
    vecs.push_back(mk(0,0,0,0,1,8'h12, 1,0,0,0,    0,0,0,      1,0));
    vecs.push_back(mk(0,0,0,0,1,8'h34, 1,0,0,0,    0,0,0,      1,0));
    vecs.push_back(mk(0,0,0,0,1,8'hFF, 0,0,0,0,    1,0,16'h1234,1,0));
    vecs.push_back(mk(0,0,0,0,1,8'h56, 1,0,0,0,    0,0,0,      1,0));
    vecs.push_back(mk(0,0,0,0,1,8'h78, 1,0,0,0,    0,0,0,      1,0));
    vecs.push_back(mk(0,0,0,0,1,8'hFF, 0,0,0,0,    1,1,16'h5678,1,0));
    vecs.push_back(mk(0,0,0,0,1,8'h9A, 1,0,0,0,    0,0,0,      1,0));
    vecs.push_back(mk(0,0,0,0,1,8'hBC, 1,0,0,0,    0,0,0,      1,0));
    vecs.push_back(mk(0,0,0,0,1,8'hFF, 0,0,0,0,    1,2,16'h9ABC,1,0));
`ifdef INSTR_LOAD_CHECKSUM_EN
    vecs.push_back(mk(0,0,0,0,1,8'h6A, 1,0,0,0,    0,0,0,      1,0));
`endif
    vecs.push_back(mk(0,0,1,0,0,8'h00, 0,1,0,0,    0,0,0,      0,1));
    vecs.push_back(mk(0,0,1,1,0,8'h00, 0,1,0,0,    0,0,0,      0,0));
    vecs.push_back(mk(0,0,1,2,0,8'h00, 0,1,1,8'h34,0,0,0,      0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00, 0,1,1,8'h78,0,0,0,      0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00, 0,1,1,8'hBC,0,0,0,      0,0));
    vecs.push_back(mk(0,0,0,0,0,8'h00, 0,1,0,0,    0,0,0,      0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      load_start = vecs[i].ls; load_len = vecs[i].len;
      fetch_req = vecs[i].fr; fetch_addr = vecs[i].fa;
      rx_valid = vecs[i].rv; rx_data = vecs[i].rd;
      @(negedge clk);
      check($sformatf("v%0d_rx_ready", i), rx_ready, vecs[i].e_rdy);
      check($sformatf("v%0d_fetch_ready", i), fetch_ready, vecs[i].e_frdy);
      check($sformatf("v%0d_fetch_valid", i), fetch_valid, vecs[i].e_fv);
      if (vecs[i].e_fv) check($sformatf("v%0d_fetch_data", i), fetch_data, vecs[i].e_fd);
      check($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_w_addr", i), mem_w_addr, vecs[i].e_wa);
        check($sformatf("v%0d_w_instr", i), mem_w_instr, vecs[i].e_wd);
      end
      check($sformatf("v%0d_busy", i), busy_load, vecs[i].e_busy);
      check($sformatf("v%0d_done", i), load_done, vecs[i].e_done);
      check($sformatf("v%0d_err", i), load_err, 0);
      tick();
    end
    fetch_req = 0; rx_valid = 0; load_start = 0;

    // Reset after 3 of 4 bytes of a 2-word session.
    done_snap = done_cnt;
    load_start = 1; load_len = 8'd1; tick(); load_start = 0;
    rx_valid = 1;
    rx_data = 8'h11; tick();
    rx_data = 8'h22; tick();
    rx_data = 8'hFF; tick();
    rx_data = 8'h33; tick();
    rx_valid = 0; rst = 1; tick(); rst = 0;
    @(negedge clk);
    check("rst_mid_busy", busy_load, 0);
    check("rst_mid_rx_ready", rx_ready, 0);
    check("rst_mid_fetch_ready", fetch_ready, 1);
    check("rst_mid_word0", mem_model[0], 16'h1122);
    check("rst_mid_word1", mem_model[1], 16'h5678);
    fetch_req = 1; fetch_addr = 8'd0;
    @(posedge clk); #1 fetch_req = 0;
    tick();
    @(negedge clk);
    check("rst_mid_fetch_valid", fetch_valid, 1);
    check("rst_mid_fetch_data", fetch_data, 8'h22);
    check("rst_mid_no_done", done_cnt, done_snap);
    tick();

    // Full-depth 256-word session with rx_valid held high.
    byte_q.delete(); exp_w.delete(); csum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      byte_q.push_back(i[7:0]);
      byte_q.push_back(~i[7:0]);
      csum = csum + i[7:0] + ~i[7:0];
      exp_w.push_back({i[7:0], i[7:0], ~i[7:0]});
    end
`ifdef INSTR_LOAD_CHECKSUM_EN
    byte_q.push_back(csum);
`endif
    done_snap = done_cnt;
    run_session(8'd255);
    check("full_writes", n_writes, 256);
    check("full_bad_writes", bad_writes, 0);
`ifdef INSTR_LOAD_CHECKSUM_EN
    check("full_busy_cycles", busy_cycles, 769);
`else
    check("full_busy_cycles", busy_cycles, 768);
`endif
    check("full_done_once", done_cnt - done_snap, 1);
    check("full_err", load_err, 0);
    check("full_mem_255", mem_model[255], 16'hFF00);

    // Single-word session after the wrap starts again at address 0.
    byte_q.delete(); exp_w.delete();
    byte_q.push_back(8'hAB); byte_q.push_back(8'hCD);
`ifdef INSTR_LOAD_CHECKSUM_EN
    byte_q.push_back(8'h78);
`endif
    exp_w.push_back({8'h00, 16'hABCD});
    run_session(8'd0);
    check("one_writes", n_writes, 1);
    check("one_bad_writes", bad_writes, 0);

    // Checksum good / bad, stickiness, and clear on the next load_start.
    byte_q.delete(); exp_w.delete();
    byte_q.push_back(8'h01); byte_q.push_back(8'h02);
`ifdef INSTR_LOAD_CHECKSUM_EN
    byte_q.push_back(8'h03);
`endif
    exp_w.push_back({8'h00, 16'h0102});
    run_session(8'd0);
    @(negedge clk);
    check("csum_good_err", load_err, 0);
    check("csum_good_rx_ready", rx_ready, 0);
    check("csum_good_writes", n_writes, 1);
    tick();
`ifdef INSTR_LOAD_CHECKSUM_EN
    byte_q.delete(); exp_w.delete();
    byte_q.push_back(8'h01); byte_q.push_back(8'h02); byte_q.push_back(8'h04);
    exp_w.push_back({8'h00, 16'h0102});
    run_session(8'd0);
    @(negedge clk);
    check("csum_bad_err", load_err, 1);
    repeat (3) tick();
    @(negedge clk);
    check("csum_bad_sticky", load_err, 1);
    tick();
    load_start = 1; load_len = 0; tick(); load_start = 0;
    @(negedge clk);
    check("csum_err_cleared", load_err, 0);
    check("csum_new_session_busy", busy_load, 1);
    tick();
    rst = 1; tick(); rst = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
